// File: rtl/router_fetch_ctrl.sv
// rtl/router_fetch_ctrl.sv - sequences BRAM line reads for a 16-lane byte request and gathers router bytes
// One request in, minimum covering run of line reads out, one collected 128-bit word to the PE array.
module router_fetch_ctrl #(
  parameter int ADDR_W   = 13,
  parameter int LANES    = 16,
  parameter int LINE_B   = 16,
  parameter int BRAM_LAT = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [LANES*ADDR_W-1:0] req_addr_i,
  output logic [ADDR_W-1:0]       bram_addr_o,
  output logic                    bram_en_o,
  output logic [ADDR_W-1:0]       rt_addr_o,
  output logic                    rt_en_o,
  input  logic [LANES-1:0]        rt_valid_i,
  input  logic [LANES*8-1:0]      rt_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LANES*8-1:0]      out_data_o,
  output logic                    busy_o
);

  localparam int SHIFT = $clog2(LINE_B);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_FETCH, S_DRAIN, S_HOLD} state_t;

  state_t                    state_q, state_d;
  logic [LANES*ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]         cur_q, cur_d;
  logic [ADDR_W-1:0]         rem_q, rem_d;
  logic [LANES-1:0]          mask_q, mask_d;
  logic [LANES*8-1:0]        data_q, data_d;
  logic [BRAM_LAT-1:0]       en_pipe_q;
  logic [ADDR_W-1:0]         addr_pipe_q [BRAM_LAT];

  logic [ADDR_W-1:0] amin, amax, lane_a, span;
  logic              pend;

  always_comb begin
    amin   = '1;
    amax   = '0;
    lane_a = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_a = addr_q[i*ADDR_W +: ADDR_W];
      if (lane_a < amin) amin = lane_a;
      if (lane_a > amax) amax = lane_a;
    end
    span = amax - amin;
  end

  // Reads still in the delay pipe that have not yet reached the router stage.
  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < BRAM_LAT - 1; i++) pend = pend | en_pipe_q[i];
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    mask_d  = mask_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        cur_d   = amin;
        rem_d   = (span >> SHIFT) + ADDR_W'(1);
        mask_d  = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        cur_d = cur_q + ADDR_W'(LINE_B);
        rem_d = rem_q - ADDR_W'(1);
        if (rem_q == ADDR_W'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!pend) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // First hit wins: a lane already captured ignores later overlapping lines.
    if (rt_en_o) begin
      for (int i = 0; i < LANES; i++) begin
        if (rt_valid_i[i] && !mask_q[i]) begin
          data_d[i*8 +: 8] = rt_data_i[i*8 +: 8];
          mask_d[i]        = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cur_q     <= '0;
      rem_q     <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      en_pipe_q <= '0;
      for (int i = 0; i < BRAM_LAT; i++) addr_pipe_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      cur_q          <= cur_d;
      rem_q          <= rem_d;
      mask_q         <= mask_d;
      data_q         <= data_d;
      en_pipe_q[0]   <= bram_en_o;
      addr_pipe_q[0] <= bram_addr_o;
      for (int i = 1; i < BRAM_LAT; i++) begin
        en_pipe_q[i]   <= en_pipe_q[i-1];
        addr_pipe_q[i] <= addr_pipe_q[i-1];
      end
    end
  end

  assign bram_en_o   = (state_q == S_FETCH);
  assign bram_addr_o = cur_q;
  assign rt_en_o     = en_pipe_q[BRAM_LAT-1];
  assign rt_addr_o   = addr_pipe_q[BRAM_LAT-1];
  assign req_ready_o = (state_q == S_IDLE) && !rst_i;
  assign out_valid_o = (state_q == S_HOLD);
  assign out_data_o  = data_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule
